// File: rtl/result_serializer.sv
// result_serializer: turns one parallel result vector into a word stream, feature-major then m.
// Define RESULT_SERIALIZER_DOUBLE_BUFFER_EN for a 2-slot ping-pong buffer; default build has 1 slot.
module result_serializer #(
  parameter int unsigned PRECISION    = 8,
  parameter int unsigned NUM_FEATURES = 1,
  parameter int unsigned M            = 16,
  localparam int unsigned NumWords    = NUM_FEATURES * M,
  localparam int unsigned IdxW        = (NumWords > 1) ? $clog2(NumWords) : 1
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic                                         ce,
  input  logic                                         in_valid,
  output logic                                         out_ready,
  input  logic [NUM_FEATURES-1:0][M-1:0][PRECISION-1:0] vec,
  output logic                                         out_valid,
  input  logic                                         in_ready,
  output logic [PRECISION-1:0]                         word,
  output logic [IdxW-1:0]                              word_index,
  output logic                                         last
);

`ifdef RESULT_SERIALIZER_DOUBLE_BUFFER_EN
  localparam int unsigned Depth = 2;
`else
  localparam int unsigned Depth = 1;
`endif
  localparam logic [1:0]      DepthCnt = 2'(Depth);
  localparam logic [IdxW-1:0] LastIdx  = IdxW'(NumWords - 1);

  typedef enum logic [0:0] {StIdle, StStream} state_e;

  state_e state_q, state_d;

  // Word f*M+m lives at flat position f*M+m, so a vector maps onto a slot bit-for-bit.
  logic [Depth-1:0][NumWords-1:0][PRECISION-1:0] slot_q;

  logic [IdxW-1:0] idx_q, idx_d;
  logic [1:0]      count_q, count_d;
  logic            wr_ptr_q, wr_ptr_d;
  logic            rd_ptr_q, rd_ptr_d;
  logic            out_ready_q;
  logic            vec_acc, word_acc, final_acc;

  assign out_valid  = (state_q == StStream);
  assign out_ready  = out_ready_q;
  assign word       = slot_q[rd_ptr_q][idx_q];
  assign word_index = idx_q;
  assign last       = out_valid && (idx_q == LastIdx);

  assign vec_acc   = in_valid && out_ready_q && ce;
  assign word_acc  = out_valid && in_ready && ce;
  assign final_acc = word_acc && (idx_q == LastIdx);

  always_comb begin
    idx_d   = idx_q;
    count_d = count_q + {1'b0, vec_acc} - {1'b0, final_acc};
    if (word_acc) begin
      idx_d = final_acc ? '0 : idx_q + IdxW'(1);
    end
  end

`ifdef RESULT_SERIALIZER_DOUBLE_BUFFER_EN
  assign wr_ptr_d = vec_acc ? ~wr_ptr_q : wr_ptr_q;
  assign rd_ptr_d = final_acc ? ~rd_ptr_q : rd_ptr_q;
`else
  assign wr_ptr_d = wr_ptr_q;
  assign rd_ptr_d = rd_ptr_q;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (vec_acc) state_d = StStream;
      end
      StStream: begin
        // A vector pending or arriving now keeps the stream going without a gap.
        if (final_acc && (count_d == 2'd0)) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      slot_q      <= '0;
      idx_q       <= '0;
      count_q     <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      out_ready_q <= 1'b0;
    end else if (ce) begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      count_q     <= count_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      out_ready_q <= (count_d < DepthCnt);
      if (vec_acc) slot_q[wr_ptr_q] <= vec;
    end
  end

endmodule

// File: tb/tb_result_serializer.sv
// Bench for result_serializer: directed scenarios plus random traffic against a queue-level model.
// Honours RESULT_SERIALIZER_DOUBLE_BUFFER_EN to pick the expected slot count.
module tb_result_serializer;
  localparam int unsigned P  = 8;
  localparam int unsigned NF = 1;
  localparam int unsigned MW = 16;
  localparam int unsigned NW = NF * MW;
`ifdef RESULT_SERIALIZER_DOUBLE_BUFFER_EN
  localparam int Depth = 2;
`else
  localparam int Depth = 1;
`endif

  typedef logic [NF-1:0][MW-1:0][P-1:0] vec_t;

  logic       clk = 1'b0;
  logic       rst, ce, in_valid, in_ready;
  vec_t       vec;
  logic       out_ready, out_valid, last;
  logic [P-1:0] word;
  logic [3:0] word_index;

  result_serializer #(
    .PRECISION   (P),
    .NUM_FEATURES(NF),
    .M           (MW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ce        (ce),
    .in_valid  (in_valid),
    .out_ready (out_ready),
    .vec       (vec),
    .out_valid (out_valid),
    .in_ready  (in_ready),
    .word      (word),
    .word_index(word_index),
    .last      (last)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Model: words of accepted vectors waiting to be handed out, and vectors still resident.
  logic [P-1:0] m_data[$];
  int unsigned  m_idx[$];
  int           resident  = 0;
  bit           exp_ready = 1'b0;
  bit           chk_en    = 1'b0;
  bit           m_vacc    = 1'b0;

  task automatic expect_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic vec_t fill(input logic [P-1:0] base);
    vec_t v;
    for (int f = 0; f < NF; f++)
      for (int m = 0; m < MW; m++) v[f][m] = base + P'(f * MW + m);
    return v;
  endfunction

  // Check outputs against the model, advance the model with the current inputs, then clock.
  task automatic tick();
    bit w_acc, v_acc;
    if (chk_en) begin
      expect_eq("out_ready", 32'(out_ready), 32'(exp_ready));
      expect_eq("out_valid", 32'(out_valid), 32'(m_data.size() != 0));
      if (m_data.size() != 0) begin
        expect_eq("word", 32'(word), 32'(m_data[0]));
        expect_eq("word_index", 32'(word_index), m_idx[0]);
        expect_eq("last", 32'(last), 32'(m_idx[0] == NW - 1));
      end else begin
        expect_eq("last_idle", 32'(last), 32'd0);
      end
    end
    chk_en = 1'b1;
    m_vacc = 1'b0;
    if (rst) begin
      m_data.delete();
      m_idx.delete();
      resident  = 0;
      exp_ready = 1'b0;
    end else if (ce) begin
      w_acc = (m_data.size() != 0) && in_ready;
      v_acc = in_valid && exp_ready;
      if (w_acc) begin
        if (m_idx[0] == NW - 1) resident--;
        void'(m_data.pop_front());
        void'(m_idx.pop_front());
      end
      if (v_acc) begin
        for (int f = 0; f < NF; f++)
          for (int m = 0; m < MW; m++) begin
            m_data.push_back(vec[f][m]);
            m_idx.push_back(f * MW + m);
          end
        resident++;
        m_vacc = 1'b1;
      end
      exp_ready = (resident < Depth);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int first_c, last_c, nacc, lasts;

    // Reset, then out_ready rises on the first edge without reset.
    rst = 1'b1; ce = 1'b1; in_valid = 1'b0; in_ready = 1'b1; vec = '0;
    repeat (3) tick();
    expect_eq("rst_word", 32'(word), 32'd0);
    expect_eq("rst_index", 32'(word_index), 32'd0);
    rst = 1'b0;
    tick();
    expect_eq("ready_after_rst", 32'(out_ready), 32'd1);

    // Single vector 0x10..0x1F.
    vec = fill(8'h10); in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    expect_eq("first_word", 32'(word), 32'h10);
    repeat (18) tick();

    // Backpressure with in_ready toggling every cycle.
    vec = fill(8'h40); in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int c = 0; c < 36; c++) begin
      in_ready = ((c % 2) == 0);
      tick();
    end
    in_ready = 1'b1;
    repeat (2) tick();

    // Back-to-back vectors with in_valid held high.
    first_c = -1; last_c = -1; nacc = 0;
    vec = fill(8'h00); in_valid = 1'b1;
    for (int c = 0; c < 50; c++) begin
      tick();
      if (m_vacc) begin
        nacc++;
        if (nacc == 1) vec = fill(8'h80);
        else in_valid = 1'b0;
      end
      if (out_valid === 1'b1 && first_c < 0) first_c = c;
      if (out_valid === 1'b1 && word === 8'h8f && last_c < 0) last_c = c;
    end
    expect_eq("b2b_span", 32'(last_c - first_c + 1), (Depth == 2) ? 32'd32 : 32'd33);

    // Three vectors offered while the consumer stalls.
    lasts = 0; nacc = 0;
    in_ready = 1'b0; vec = fill(8'ha0); in_valid = 1'b1;
    for (int c = 0; c < 70; c++) begin
      if (c == 6) in_ready = 1'b1;
      if (out_valid === 1'b1 && in_ready && last === 1'b1) lasts++;
      tick();
      if (m_vacc) begin
        nacc++;
        if (nacc == 1) vec = fill(8'hb0);
        else if (nacc == 2) vec = fill(8'hc0);
        else in_valid = 1'b0;
      end
    end
    expect_eq("full_last_count", 32'(lasts), 32'd3);

    // Clock enable low for 5 cycles at index 7.
    vec = fill(8'h20); in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (7) tick();
    ce = 1'b0;
    repeat (5) begin
      tick();
      expect_eq("ce_freeze_idx", 32'(word_index), 32'd7);
      expect_eq("ce_freeze_word", 32'(word), 32'h27);
    end
    ce = 1'b1;
    repeat (10) tick();

    // Reset pulse at index 9, then a fresh vector.
    vec = fill(8'h30); in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (9) tick();
    expect_eq("pre_rst_idx", 32'(word_index), 32'd9);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    expect_eq("rst_mid_valid", 32'(out_valid), 32'd0);
    tick();
    vec = fill(8'h50); in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    expect_eq("post_rst_word", 32'(word), 32'h50);
    expect_eq("post_rst_idx", 32'(word_index), 32'd0);
    repeat (17) tick();

    // Random traffic.
    for (int c = 0; c < 600; c++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_ready = ($urandom_range(0, 3) != 0);
      ce       = ($urandom_range(0, 7) != 0);
      for (int f = 0; f < NF; f++)
        for (int m = 0; m < MW; m++) vec[f][m] = P'($urandom);
      tick();
    end
    in_valid = 1'b0; in_ready = 1'b1; ce = 1'b1;
    repeat (40) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
